ov7670_stream_gen: RTL and testbench



---
 rtl/ov7670_stream_gen.sv | 191 +++++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
`default_nettype none
// ov7670_stream_gen: OV7670 DVP camera emulator (vsync/href/pix_byte, RGB444, two bytes per pixel).
// Rev 1.0 - initial release.
module ov7670_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int VBP         = 17,
  parameter int VFP         = 10
) (
  input  logic        i_clk,
  input  logic        i_rstn_clk,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [1:0]  i_pattern,
  input  logic [11:0] i_solid,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_pix_byte,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int L  = 2*H_ACTIVE + H_BLANK;
  localparam int F  = VSYNC_LINES + VBP + V_ACTIVE + VFP;
  localparam int BW = $clog2(L);
  localparam int LW = (F > 1) ? $clog2(F) : 1;
  localparam int XW = $clog2(H_ACTIVE);

  localparam logic [BW-1:0] C_LAST_BYTE  = BW'(L - 1);
  localparam logic [BW-1:0] C_HREF_BYTES = BW'(2*H_ACTIVE);
  localparam logic [LW-1:0] C_LAST_LINE  = LW'(F - 1);
  localparam logic [LW-1:0] C_VS_END     = LW'(VSYNC_LINES);
  localparam logic [LW-1:0] C_ACT_START  = LW'(VSYNC_LINES + VBP);
  localparam logic [LW-1:0] C_ACT_END    = LW'(VSYNC_LINES + VBP + V_ACTIVE);
  localparam logic [XW-1:0] C_BAR_LAST   = XW'(H_ACTIVE/8 - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [LW-1:0]   line_q, line_d;
  logic [7:0]      frame_q, frame_d;
  logic            stop_q, stop_d;
  logic [1:0]      pat_q, pat_d;
  logic [11:0]     solid_q, solid_d;
  logic [XW-1:0]   bar_px_q, bar_px_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      pix_q, pix_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            last_byte, last_line;
  logic [11:0]     pixel;

  // Counters track the byte currently on the bus; outputs are computed from the next position.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    line_d    = line_q;
    frame_d   = frame_q;
    stop_d    = stop_q;
    pat_d     = pat_q;
    solid_d   = solid_q;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    last_byte = (byte_q == C_LAST_BYTE);
    last_line = (line_q == C_LAST_LINE);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_RUN;
          byte_d    = '0;
          line_d    = '0;
          frame_d   = '0;
          stop_d    = i_stop;
          pat_d     = i_pattern;
          solid_d   = i_solid;
          bar_px_d  = '0;
          bar_idx_d = '0;
        end
      end
      default: begin
        if (i_stop) stop_d = 1'b1;
        if (last_byte && last_line && stop_q) begin
          state_d   = S_IDLE;
          byte_d    = '0;
          line_d    = '0;
          stop_d    = 1'b0;
          bar_px_d  = '0;
          bar_idx_d = '0;
        end else begin
          byte_d = last_byte ? '0 : byte_q + BW'(1);
          if (last_byte) line_d = last_line ? '0 : line_q + LW'(1);
          if (last_byte && last_line) begin
            frame_d = frame_q + 8'd1;
            pat_d   = i_pattern;
            solid_d = i_solid;
          end
          // Bar position advances on each even byte, i.e. on each new pixel.
          if (byte_d == '0) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
          end else if (!byte_d[0]) begin
            if (bar_px_q == C_BAR_LAST) begin
              bar_px_d  = '0;
              bar_idx_d = bar_idx_q + 3'd1;
            end else begin
              bar_px_d = bar_px_q + XW'(1);
            end
          end
        end
      end
    endcase

    case (pat_d)
      2'd0: begin
        case (bar_idx_d)
          3'd0:    pixel = 12'hFFF;
          3'd1:    pixel = 12'hFF0;
          3'd2:    pixel = 12'h0FF;
          3'd3:    pixel = 12'h0F0;
          3'd4:    pixel = 12'hF0F;
          3'd5:    pixel = 12'hF00;
          3'd6:    pixel = 12'h00F;
          default: pixel = 12'h000;
        endcase
      end
      2'd1:    pixel = 12'(byte_d >> 1) + 12'(line_d - C_ACT_START) + {4'h0, frame_d};
      default: pixel = solid_d;
    endcase

    vsync_d = 1'b0;
    href_d  = 1'b0;
    pix_d   = 8'h00;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (state_d == S_RUN) begin
      busy_d  = 1'b1;
      vsync_d = (line_d < C_VS_END);
      href_d  = (line_d >= C_ACT_START) && (line_d < C_ACT_END) && (byte_d < C_HREF_BYTES);
      done_d  = (byte_d == C_LAST_BYTE) && (line_d == C_LAST_LINE);
      if (href_d) pix_d = byte_d[0] ? pixel[7:0] : {4'h0, pixel[11:8]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn_clk) begin
    if (!i_rstn_clk) begin
      state_q   <= S_IDLE;
      byte_q    <= '0;
      line_q    <= '0;
      frame_q   <= '0;
      stop_q    <= 1'b0;
      pat_q     <= '0;
      solid_q   <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      pix_q     <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      stop_q    <= stop_d;
      pat_q     <= pat_d;
      solid_q   <= solid_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      pix_q     <= pix_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_vsync      = vsync_q;
  assign o_href       = href_q;
  assign o_pix_byte   = pix_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_stream_gen.sv
`default_nettype none
// Bench for ov7670_stream_gen: per-cycle scoreboard of expected bus values plus targeted timing checks.
module tb_ov7670_stream_gen;
  localparam int HA = 8, HB = 4, VA = 4, VSL = 1, VBPL = 1, VFPL = 1;
  localparam int L  = 2*HA + HB;
  localparam int F  = VSL + VBPL + VA + VFPL;
  localparam int FR = L*F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [1:0]  pattern;
  logic [11:0] solid;
  logic        vsync, href, busy, done;
  logic [7:0]  pix;
  logic [11:0] obs;
  logic [11:0] exp_v;
  logic [11:0] sb[$];
  logic [11:0] bars[8];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VSL), .VBP(VBPL), .VFP(VFPL)
  ) dut (
    .i_clk(clk), .i_rstn_clk(rst_n), .i_start(start), .i_stop(stop),
    .i_pattern(pattern), .i_solid(solid),
    .o_vsync(vsync), .o_href(href), .o_pix_byte(pix),
    .o_busy(busy), .o_frame_done(done)
  );

  assign obs = {vsync, href, busy, done, pix};

  // Expected {vsync, href, busy, frame_done, pix_byte} for every cycle of one frame.
  function automatic void push_frame(input logic [1:0] pat, input logic [11:0] sol, input int fc);
    for (int ln = 0; ln < F; ln++) begin
      for (int b = 0; b < L; b++) begin
        logic vs, hr, dn;
        logic [7:0] pb;
        logic [11:0] px;
        int x, y;
        vs = (ln < VSL);
        hr = (ln >= VSL + VBPL) && (ln < VSL + VBPL + VA) && (b < 2*HA);
        dn = (ln == F - 1) && (b == L - 1);
        x  = b / 2;
        y  = ln - (VSL + VBPL);
        px = 12'h000;
        pb = 8'h00;
        if (hr) begin
          if (pat == 2'd0)      px = bars[x / (HA/8)];
          else if (pat == 2'd1) px = 12'((x + y + fc) % 4096);
          else                  px = sol;
          pb = (b % 2 == 1) ? px[7:0] : {4'h0, px[11:8]};
        end
        sb.push_back({vs, hr, 1'b1, dn, pb});
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_start(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pattern = 2'd0; solid = 12'h000;
    #3;
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL reset_outputs got=%h exp=000", obs); end
    step(); step();
    rst_n = 1'b1;
    stop = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (obs !== 12'h000) begin errors++; $display("FAIL idle_stop_only k=%0d got=%h exp=000", k, obs); end
    end
    stop = 1'b0;
  endtask

  task automatic test_frame_timing();
    int vs_high = 0, vs_fall = -1, nrise = 0;
    int rise[4], fall[4];
    logic prev = 1'b0;
    do_reset();
    pattern = 2'd0;
    push_frame(2'd0, 12'h000, 0);
    pulse_start(1'b0);
    for (int k = 0; k < FR; k++) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sb_timing k=%0d got=%h exp=%h", k, obs, exp_v); end
      if (vsync) vs_high++;
      else if (vs_fall < 0 && vs_high > 0) vs_fall = k;
      if (href && !prev) begin if (nrise < 4) rise[nrise] = k; nrise++; end
      if (!href && prev && nrise >= 1 && nrise <= 4) fall[nrise-1] = k;
      prev = href;
      step();
    end
    checks++;
    if (vs_high !== 20 || vs_fall !== 20) begin
      errors++; $display("FAIL vsync_width got=%0d fall=%0d exp=20", vs_high, vs_fall);
    end
    checks++;
    if (rise[0] - vs_fall !== 20) begin errors++; $display("FAIL href_delay got=%0d exp=20", rise[0] - vs_fall); end
    checks++;
    if (nrise !== 4) begin errors++; $display("FAIL href_pulses got=%0d exp=4", nrise); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fall[i] - rise[i] !== 16) begin errors++; $display("FAIL href_len%0d got=%0d exp=16", i, fall[i] - rise[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rise[i+1] - fall[i] !== 4) begin errors++; $display("FAIL href_gap%0d got=%0d exp=4", i, rise[i+1] - fall[i]); end
    end
  endtask

  task automatic test_colour_bars();
    logic [7:0] eb[16];
    eb = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
           8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
    do_reset();
    pattern = 2'd0;
    push_frame(2'd0, 12'h000, 0);
    pulse_start(1'b0);
    for (int k = 0; k < FR; k++) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sb_bars k=%0d got=%h exp=%h", k, obs, exp_v); end
      if (k >= 2*L && k < 2*L + 16) begin
        checks++;
        if (pix !== eb[k - 2*L]) begin errors++; $display("FAIL bar_byte%0d got=%h exp=%h", k - 2*L, pix, eb[k - 2*L]); end
      end
      if (!href) begin
        checks++;
        if (pix !== 8'h00) begin errors++; $display("FAIL pix_blank k=%0d got=%h exp=00", k, pix); end
      end
      step();
    end
  endtask

  task automatic test_ramp();
    logic [7:0] b[6];
    int dk[2];
    int nd = 0;
    do_reset();
    pattern = 2'd1;
    push_frame(2'd1, 12'h000, 0);
    push_frame(2'd1, 12'h000, 1);
    pulse_start(1'b0);
    for (int k = 0; k < 2*FR; k++) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sb_ramp k=%0d got=%h exp=%h", k, obs, exp_v); end
      if (k == 3*L)           b[0] = pix;
      if (k == 3*L + 1)       b[1] = pix;
      if (k == FR + 2*L)      b[2] = pix;
      if (k == FR + 2*L + 1)  b[3] = pix;
      if (k == FR + 2*L + 14) b[4] = pix;
      if (k == FR + 2*L + 15) b[5] = pix;
      if (done) begin if (nd < 2) dk[nd] = k; nd++; end
      step();
    end
    checks++;
    if ({b[0][3:0], b[1]} !== 12'h001) begin errors++; $display("FAIL ramp_f0_l1_p0 got=%h exp=001", {b[0][3:0], b[1]}); end
    checks++;
    if ({b[2][3:0], b[3]} !== 12'h001) begin errors++; $display("FAIL ramp_f1_l0_p0 got=%h exp=001", {b[2][3:0], b[3]}); end
    checks++;
    if ({b[4][3:0], b[5]} !== 12'h008) begin errors++; $display("FAIL ramp_f1_l0_p7 got=%h exp=008", {b[4][3:0], b[5]}); end
    checks++;
    if (nd !== 2 || dk[0] !== FR - 1 || dk[1] - dk[0] !== FR) begin
      errors++; $display("FAIL frame_done_spacing got n=%0d at %0d,%0d exp 2 at 139,279", nd, dk[0], dk[1]);
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] b0, b1;
    int nd = 0;
    do_reset();
    pattern = 2'd2;
    solid = 12'hABC;
    push_frame(2'd2, 12'hABC, 0);
    pulse_start(1'b1);
    for (int k = 0; k < FR; k++) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sb_one_shot k=%0d got=%h exp=%h", k, obs, exp_v); end
      if (k == 2*L)     b0 = pix;
      if (k == 2*L + 1) b1 = pix;
      if (done) nd++;
      step();
    end
    checks++;
    if (b0 !== 8'h0A || b1 !== 8'hBC) begin errors++; $display("FAIL solid_bytes got=%h,%h exp=0A,BC", b0, b1); end
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL one_shot_done got=%0d exp=1", nd); end
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (obs !== 12'h000) begin errors++; $display("FAIL one_shot_idle k=%0d got=%h exp=000", k, obs); end
      step();
    end
  endtask

  task automatic test_stop_mid();
    int nd = 0;
    do_reset();
    pattern = 2'd0;
    push_frame(2'd0, 12'h000, 0);
    pulse_start(1'b0);
    for (int k = 0; k < FR; k++) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sb_stop_mid k=%0d got=%h exp=%h", k, obs, exp_v); end
      if (done) nd++;
      stop  = (k == 3*L + 5);
      start = (k == 80);
      step();
    end
    stop = 1'b0;
    start = 1'b0;
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL stop_mid_done got=%0d exp=1", nd); end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs !== 12'h000) begin errors++; $display("FAIL stop_mid_idle k=%0d got=%h exp=000", k, obs); end
      step();
    end
  endtask

  task automatic test_pattern_switch_reset();
    do_reset();
    pattern = 2'd0;
    solid = 12'h5A3;
    push_frame(2'd0, 12'h5A3, 0);
    push_frame(2'd2, 12'h5A3, 1);
    pulse_start(1'b0);
    for (int k = 0; k < FR + 2*L + 8; k++) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sb_switch k=%0d got=%h exp=%h", k, obs, exp_v); end
      if (k == 50) pattern = 2'd2;
      step();
    end
    checks++;
    if (href !== 1'b1 || pix !== 8'h05) begin errors++; $display("FAIL pre_reset_href got=%b,%h exp=1,05", href, pix); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL async_reset got=%h exp=000", obs); end
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (busy !== 1'b0 || obs !== 12'h000) begin errors++; $display("FAIL post_reset_idle k=%0d got=%h exp=000", k, obs); end
    end
    pulse_start(1'b0);
    checks++;
    if (vsync !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL restart got vs=%b busy=%b exp=1,1", vsync, busy); end
  endtask

  initial begin
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    test_reset();
    test_frame_timing();
    test_colour_bars();
    test_ramp();
    test_one_shot();
    test_stop_mid();
    test_pattern_switch_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
